// File: rtl/fdivsqrt_otfc_seq_pkg.sv
// Shared types and helpers for the sequential on-the-fly converter.
package fdivsqrt_otfc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot digit width: {+2,+1,-1,-2} for radix 4, {+1,-1} for radix 2.
  function automatic int digit_width(input int radix);
    return (radix == 4) ? 4 : 2;
  endfunction

endpackage

// File: rtl/fdivsqrt_otfc_seq_if.sv
// Digit/control bus between digit selection, the converter and postprocessing.
interface fdivsqrt_otfc_seq_if
  import fdivsqrt_otfc_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int RADIX = 4,
  parameter int CNTW  = 7
);
  localparam int DW = digit_width(RADIX);

  logic             start;
  logic [WIDTH:0]   uinit;
  logic [WIDTH:0]   uminit;
  logic [WIDTH:0]   cinit;
  logic [CNTW-1:0]  iters;
  logic             digit_valid;
  logic [DW-1:0]    udigit;
  logic             rem_neg;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   u;
  logic [WIDTH:0]   um;
  logic [WIDTH:0]   result;
  logic             digit_err;

  modport master (
    output start, uinit, uminit, cinit, iters, digit_valid, udigit, rem_neg,
    input  busy, done, u, um, result, digit_err
  );

  modport slave (
    input  start, uinit, uminit, cinit, iters, digit_valid, udigit, rem_neg,
    output busy, done, u, um, result, digit_err
  );

endinterface

// File: rtl/fdivsqrt_otfc_step.sv
// Combinational U/UM next values for one accepted digit, radix 2 or 4.
module fdivsqrt_otfc_step #(
  parameter int WIDTH = 64,
  parameter int RADIX = 4,
  parameter int DW    = 4
) (
  input  logic [WIDTH:0]  c,
  input  logic [WIDTH:0]  u,
  input  logic [WIDTH:0]  um,
  input  logic [DW-1:0]   digit,
  output logic [WIDTH:0]  u_nxt,
  output logic [WIDTH:0]  um_nxt
);

  logic [WIDTH:0] c_sh1;
  logic [WIDTH:0] c_sh2;

  assign c_sh1 = c << 1;
  assign c_sh2 = c << 2;

  if (RADIX == 4) begin : g_r4
    logic [WIDTH:0] k1, k2, k3;

    assign k1 = c & ~c_sh1;
    assign k2 = c_sh1 & ~c_sh2;
    assign k3 = c & ~c_sh2;

    // Priority +2 > +1 > -1 > -2 resolves multi-hot digits.
    always_comb begin
      u_nxt  = u;
      um_nxt = um | k3;
      if (digit[3]) begin
        u_nxt  = u | k2;
        um_nxt = u | k1;
      end else if (digit[2]) begin
        u_nxt  = u | k1;
        um_nxt = u;
      end else if (digit[1]) begin
        u_nxt  = um | k3;
        um_nxt = um | k2;
      end else if (digit[0]) begin
        u_nxt  = um | k2;
        um_nxt = um | k1;
      end
    end
  end else begin : g_r2
    logic [WIDTH:0] k;

    assign k = c & ~c_sh1;

    always_comb begin
      u_nxt  = u;
      um_nxt = um | k;
      if (digit[1]) begin
        u_nxt  = u | k;
        um_nxt = u;
      end else if (digit[0]) begin
        u_nxt  = um | k;
        um_nxt = um;
      end
    end
  end

endmodule

// File: rtl/fdivsqrt_otfc_seq.sv
// Sequential on-the-fly converter owning U/UM/C and the digit counter.
// Optional illegal-digit check enabled by FDIVSQRT_OTFC_DIGITCHK_EN.
//
// state | meaning
// IDLE  | waiting for start; u/um keep the last result
// RUN   | accepting digits while digit_valid is high
// DONE  | one-cycle completion, result selected by rem_neg
module fdivsqrt_otfc_seq
  import fdivsqrt_otfc_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int RADIX = 4,
  parameter int CNTW  = 7
) (
  input logic             clk,
  input logic             reset,
  fdivsqrt_otfc_seq_if.slave bus
);

  localparam int DW = digit_width(RADIX);
  localparam int SH = (RADIX == 4) ? 2 : 1;

  if (RADIX != 2 && RADIX != 4) begin : g_bad_radix
    $error("fdivsqrt_otfc_seq: RADIX must be 2 or 4");
  end

  state_t          state, state_nxt;
  logic [WIDTH:0]  u_q, um_q, c_q;
  logic [WIDTH:0]  u_step, um_step, c_shift;
  logic [CNTW-1:0] count, count_inc, iters_q;
  logic            accept;

  fdivsqrt_otfc_step #(
    .WIDTH (WIDTH),
    .RADIX (RADIX),
    .DW    (DW)
  ) u_step_logic (
    .c      (c_q),
    .u      (u_q),
    .um     (um_q),
    .digit  (bus.udigit),
    .u_nxt  (u_step),
    .um_nxt (um_step)
  );

  assign count_inc = count + CNTW'(1);
  assign c_shift   = {{SH{1'b1}}, c_q[WIDTH:SH]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      RUN: begin
        if (bus.digit_valid) begin
          accept = 1'b1;
          if (count_inc == iters_q) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = state;
    endcase
    // start overrides everything, including a digit arriving the same cycle
    if (bus.start) begin
      accept    = 1'b0;
      state_nxt = (bus.iters == '0) ? DONE : RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u_q     <= '0;
      um_q    <= '0;
      c_q     <= '0;
      count   <= '0;
      iters_q <= '0;
    end else if (bus.start) begin
      u_q     <= bus.uinit;
      um_q    <= bus.uminit;
      c_q     <= bus.cinit;
      count   <= '0;
      iters_q <= bus.iters;
    end else if (accept) begin
      u_q     <= u_step;
      um_q    <= um_step;
      c_q     <= c_shift;
      count   <= count_inc;
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.u      = u_q;
  assign bus.um     = um_q;
  assign bus.result = (state == DONE) ? (bus.rem_neg ? um_q : u_q) : '0;

`ifdef FDIVSQRT_OTFC_DIGITCHK_EN
  logic digit_err_q;
  logic multi_hot;

  assign multi_hot = |(bus.udigit & (bus.udigit - DW'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      digit_err_q <= 1'b0;
    else if (bus.start)             digit_err_q <= 1'b0;
    else if (accept && multi_hot)   digit_err_q <= 1'b1;
  end

  assign bus.digit_err = digit_err_q;
`else
  assign bus.digit_err = 1'b0;
`endif

endmodule

// File: tb/tb_fdivsqrt_otfc_seq.sv
// Directed bench for the radix-2 and radix-4 converters at WIDTH=8.
module tb_fdivsqrt_otfc_seq;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

`ifdef FDIVSQRT_OTFC_DIGITCHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  fdivsqrt_otfc_seq_if #(.WIDTH(8), .RADIX(2), .CNTW(7)) if2 ();
  fdivsqrt_otfc_seq_if #(.WIDTH(8), .RADIX(4), .CNTW(7)) if4 ();

  fdivsqrt_otfc_seq #(.WIDTH(8), .RADIX(2), .CNTW(7)) dut_r2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  fdivsqrt_otfc_seq #(.WIDTH(8), .RADIX(4), .CNTW(7)) dut_r4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    {if2.start, if2.digit_valid, if2.rem_neg} = 3'b000;
    {if4.start, if4.digit_valid, if4.rem_neg} = 3'b000;
    if2.uinit = '0; if2.uminit = '0; if2.cinit = '0; if2.iters = '0; if2.udigit = '0;
    if4.uinit = '0; if4.uminit = '0; if4.cinit = '0; if4.iters = '0; if4.udigit = '0;

    #2;
    chk("rst_busy2", 32'(if2.busy), 32'd0);
    chk("rst_done2", 32'(if2.done), 32'd0);
    chk("rst_u2", 32'(if2.u), 32'h0);
    chk("rst_um4", 32'(if4.um), 32'h0);
    chk("rst_result4", 32'(if4.result), 32'h0);
    chk("rst_err4", 32'(if4.digit_err), 32'd0);
    tick(); tick();
    reset = 1'b0;

    // radix 2: +1,-1,+1 from C=0x180
    if2.start = 1'b1; if2.cinit = 9'h180; if2.uinit = '0; if2.uminit = '0; if2.iters = 7'd3;
    if2.digit_valid = 1'b1; if2.udigit = 2'b10;
    tick();
    if2.start = 1'b0;
    chk("r2_busy_run", 32'(if2.busy), 32'd1);
    chk("r2_done_c1", 32'(if2.done), 32'd0);
    tick();
    chk("r2_u_d1", 32'(if2.u), 32'h080);
    chk("r2_um_d1", 32'(if2.um), 32'h000);
    if2.udigit = 2'b01;
    tick();
    chk("r2_u_d2", 32'(if2.u), 32'h040);
    chk("r2_done_c3", 32'(if2.done), 32'd0);
    if2.udigit = 2'b10;
    if2.rem_neg = 1'b1;
    tick();
    chk("r2_done_c4", 32'(if2.done), 32'd1);
    chk("r2_u_fin", 32'(if2.u), 32'h060);
    chk("r2_um_fin", 32'(if2.um), 32'h040);
    chk("r2_result", 32'(if2.result), 32'h040);
    tick();
    chk("r2_done_gone", 32'(if2.done), 32'd0);
    chk("r2_busy_idle", 32'(if2.busy), 32'd0);
    chk("r2_result_idle", 32'(if2.result), 32'h0);
    tick();
    chk("r2_idle_ignores_digit", 32'(if2.u), 32'h060);
    if2.digit_valid = 1'b0;

    // radix 4: +2 then -1 from C=0x1C0
    if4.start = 1'b1; if4.cinit = 9'h1C0; if4.uinit = '0; if4.uminit = '0; if4.iters = 7'd2;
    if4.digit_valid = 1'b1; if4.udigit = 4'b1000; if4.rem_neg = 1'b0;
    tick();
    if4.start = 1'b0;
    tick();
    chk("r4_u_p2", 32'(if4.u), 32'h080);
    chk("r4_um_p2", 32'(if4.um), 32'h040);
    chk("r4_done_early", 32'(if4.done), 32'd0);
    if4.udigit = 4'b0010;
    tick();
    chk("r4_u_m1", 32'(if4.u), 32'h070);
    chk("r4_um_m1", 32'(if4.um), 32'h060);
    chk("r4_done", 32'(if4.done), 32'd1);
    chk("r4_result", 32'(if4.result), 32'h070);
    tick();
    chk("r4_done_gone", 32'(if4.done), 32'd0);

    // radix 4: digit 0 then +1
    if4.start = 1'b1; if4.udigit = 4'b0000;
    tick();
    if4.start = 1'b0;
    tick();
    chk("r4_u_zero", 32'(if4.u), 32'h000);
    chk("r4_um_zero", 32'(if4.um), 32'h0C0);
    if4.udigit = 4'b0100;
    tick();
    chk("r4_u_p1", 32'(if4.u), 32'h010);
    chk("r4_um_p1", 32'(if4.um), 32'h000);
    tick();
    if4.digit_valid = 1'b0;

    // radix 2 stall: 3 idle digit cycles mid-run
    if2.start = 1'b1; if2.cinit = 9'h180; if2.uinit = '0; if2.uminit = '0; if2.iters = 7'd3;
    if2.digit_valid = 1'b1; if2.udigit = 2'b10;
    tick();
    if2.start = 1'b0;
    tick();
    chk("stall_u_d1", 32'(if2.u), 32'h080);
    if2.digit_valid = 1'b0;
    tick(); tick(); tick();
    chk("stall_u_hold", 32'(if2.u), 32'h080);
    chk("stall_um_hold", 32'(if2.um), 32'h000);
    chk("stall_busy", 32'(if2.busy), 32'd1);
    chk("stall_done", 32'(if2.done), 32'd0);
    if2.digit_valid = 1'b1; if2.udigit = 2'b01;
    tick();
    chk("stall_u_d2", 32'(if2.u), 32'h040);
    chk("stall_done_c6", 32'(if2.done), 32'd0);
    if2.udigit = 2'b10;
    tick();
    chk("stall_done_c7", 32'(if2.done), 32'd1);
    chk("stall_u_fin", 32'(if2.u), 32'h060);
    chk("stall_um_fin", 32'(if2.um), 32'h040);
    tick();
    if2.digit_valid = 1'b0;

    // iters = 0 completes immediately with the init values
    if2.start = 1'b1; if2.uinit = 9'h0AA; if2.uminit = 9'h055; if2.iters = 7'd0;
    if2.rem_neg = 1'b1;
    tick();
    if2.start = 1'b0;
    chk("it0_done", 32'(if2.done), 32'd1);
    chk("it0_busy", 32'(if2.busy), 32'd0);
    chk("it0_u", 32'(if2.u), 32'h0AA);
    chk("it0_result", 32'(if2.result), 32'h055);
    tick();
    chk("it0_done_gone", 32'(if2.done), 32'd0);

    // radix 4 restart after one accepted digit
    if4.start = 1'b1; if4.cinit = 9'h1C0; if4.uinit = '0; if4.uminit = '0; if4.iters = 7'd2;
    if4.digit_valid = 1'b1; if4.udigit = 4'b1000;
    tick();
    if4.start = 1'b0;
    tick();
    chk("rs_u_before", 32'(if4.u), 32'h080);
    if4.start = 1'b1; if4.uinit = 9'h001; if4.uminit = 9'h002;
    tick();
    if4.start = 1'b0;
    chk("rs_u_reload", 32'(if4.u), 32'h001);
    chk("rs_um_reload", 32'(if4.um), 32'h002);
    chk("rs_busy", 32'(if4.busy), 32'd1);
    if4.udigit = 4'b0100;
    tick();
    chk("rs_u_d1", 32'(if4.u), 32'h041);
    chk("rs_um_d1", 32'(if4.um), 32'h001);
    chk("rs_done_early", 32'(if4.done), 32'd0);
    if4.udigit = 4'b0001;
    tick();
    chk("rs_done", 32'(if4.done), 32'd1);
    chk("rs_u_fin", 32'(if4.u), 32'h021);
    chk("rs_um_fin", 32'(if4.um), 32'h011);
    tick();
    if4.digit_valid = 1'b0;

    // async reset in mid-run, observed between clock edges
    if2.start = 1'b1; if2.cinit = 9'h180; if2.uinit = '0; if2.uminit = '0; if2.iters = 7'd3;
    if2.digit_valid = 1'b1; if2.udigit = 2'b10;
    tick();
    if2.start = 1'b0;
    tick();
    chk("ar_u_pre", 32'(if2.u), 32'h080);
    #2 reset = 1'b1;
    #1;
    chk("ar_u", 32'(if2.u), 32'h0);
    chk("ar_um", 32'(if2.um), 32'h0);
    chk("ar_busy", 32'(if2.busy), 32'd0);
    chk("ar_done", 32'(if2.done), 32'd0);
    #2 reset = 1'b0;
    if2.digit_valid = 1'b0;
    tick();

    // multi-hot digit: treated as +2, flagged when the check is built
    if4.start = 1'b1; if4.cinit = 9'h1C0; if4.uinit = '0; if4.uminit = '0; if4.iters = 7'd2;
    if4.digit_valid = 1'b1; if4.udigit = 4'b1100;
    tick();
    if4.start = 1'b0;
    chk("mh_err_pre", 32'(if4.digit_err), 32'd0);
    tick();
    chk("mh_err", 32'(if4.digit_err), 32'(ERR_EXP));
    chk("mh_u", 32'(if4.u), 32'h080);
    chk("mh_um", 32'(if4.um), 32'h040);
    if4.udigit = 4'b0000;
    tick();
    chk("mh_done", 32'(if4.done), 32'd1);
    chk("mh_err_sticky", 32'(if4.digit_err), 32'(ERR_EXP));
    if4.digit_valid = 1'b0;
    tick();
    chk("mh_err_idle", 32'(if4.digit_err), 32'(ERR_EXP));
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    chk("mh_err_clr", 32'(if4.digit_err), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
